spi_responder: RTL and testbench

SPI mode-0 slave with a 32 × 8-bit register file. It is the responder end of the SPI link that the NIOS II SoC drives as master (SS_n/SCLK/MOSI/MISO on the Arduino header). It lets a second board or bench master write and read registers, such as injected keycodes and sprite positions. The fabric sees each written byte as a one-cycle strobe and can read any register through a registered port.

---
 rtl/spi_resp_pkg.sv | 16 +
 rtl/spi_sync_edge.sv | 31 +++
 rtl/spi_responder.sv | 167 ++++++++++++++++
 tb/tb_spi_responder.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_resp_pkg.sv
// Shared types and command-byte field positions for the SPI register responder.
package spi_resp_pkg;

    typedef enum logic [1:0] {IDLE, CMD, DATA} spi_state_t;

    localparam int ADDR_MSB = 7;
    localparam int ADDR_LSB = 3;
    localparam int W_BIT    = 1;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = ADDR_MSB - ADDR_LSB + 1;

    function automatic logic [ADDR_W-1:0] cmd_addr(input logic [7:0] cmd);
        return cmd[ADDR_MSB:ADDR_LSB];
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin, with a registered edge detector.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;

    // Chain resets low so a select already held low at reset release shows no falling edge.
    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], din};
            prev_reg <= sync_reg[STAGES-1];
        end
    end

    assign level = sync_reg[STAGES-1];
    assign rise  = level & ~prev_reg;
    assign fall  = ~level & prev_reg;

endmodule

// File: rtl/spi_responder.sv
// Mode-0 SPI slave exposing a 32 x 8 register file: command byte then a burst of data bytes.
module spi_responder
    import spi_resp_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       SCLK,
    input  logic       SS_n,
    input  logic       MOSI,
    output logic       MISO,
    output logic       MISO_OE,
    input  logic [7:0] Status,
    input  logic [4:0] RdAddr,
    output logic [7:0] RdData,
    output logic       WrStrobe,
    output logic [4:0] WrAddr,
    output logic [7:0] WrData,
    output logic       Busy
);

    localparam int NUM_PINS = 3;

    logic [NUM_PINS-1:0] pin_raw, pin_level, pin_rise, pin_fall;
    logic                sclk_rise, sclk_fall, ss_rise, ss_fall, ss_level, mosi_level;
    logic                unused_edges;

    spi_state_t          state_reg, state_next;
    logic [2:0]          bit_cnt_reg;
    logic [6:0]          shift_in_reg;
    logic [7:0]          shift_out_reg;
    logic                miso_bit_reg, miso_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic                write_mode_reg;
    logic                pend1_reg, pend2_reg;
    logic [7:0]          spi_rd_reg;
    logic                wr_strobe_reg;
    logic [ADDR_W-1:0]   wr_addr_reg;
    logic [7:0]          wr_data_reg;
    logic [7:0]          rd_data_reg;
    logic [7:0]          regs [NUM_REGS];

    logic                in_xfer, byte_done;
    logic [7:0]          rx_byte;

    assign pin_raw = {MOSI, SS_n, SCLK};

    generate
        for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_sync
            spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
                .clk   (Clk),
                .srst  (Reset),
                .din   (pin_raw[gi]),
                .level (pin_level[gi]),
                .rise  (pin_rise[gi]),
                .fall  (pin_fall[gi])
            );
        end
    endgenerate

    assign sclk_rise    = pin_rise[0];
    assign sclk_fall    = pin_fall[0];
    assign ss_rise      = pin_rise[1];
    assign ss_fall      = pin_fall[1];
    assign ss_level     = pin_level[1];
    assign mosi_level   = pin_level[2];
    assign unused_edges = ^{pin_level[0], pin_rise[2], pin_fall[2]};

    assign in_xfer   = (state_reg != IDLE) && !ss_rise;
    assign byte_done = in_xfer && sclk_rise && (bit_cnt_reg == 3'd7);
    assign rx_byte   = {shift_in_reg, mosi_level};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (ss_fall) state_next = CMD;
            CMD:     if (ss_rise) state_next = IDLE;
                     else if (byte_done) state_next = DATA;
            DATA:    if (ss_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= 3'd0;
            shift_in_reg   <= 7'd0;
            shift_out_reg  <= 8'h00;
            miso_bit_reg   <= 1'b0;
            miso_reg       <= 1'b0;
            addr_reg       <= '0;
            write_mode_reg <= 1'b0;
            pend1_reg      <= 1'b0;
            pend2_reg      <= 1'b0;
            spi_rd_reg     <= 8'h00;
            wr_strobe_reg  <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= 8'h00;
        end else begin
            state_reg     <= state_next;
            wr_strobe_reg <= 1'b0;
            miso_reg      <= miso_bit_reg;
            // Read data is prefetched over two cycles; SCLK phases leave ample room before the next fall.
            spi_rd_reg    <= regs[addr_reg];
            pend1_reg     <= 1'b0;
            pend2_reg     <= pend1_reg;
            if (state_reg == IDLE) begin
                if (ss_fall) begin
                    bit_cnt_reg   <= 3'd0;
                    miso_bit_reg  <= Status[7];
                    shift_out_reg <= {Status[6:0], 1'b0};
                end
            end else if (in_xfer) begin
                if (sclk_rise) begin
                    bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                    shift_in_reg <= rx_byte[6:0];
                    if (byte_done) begin
                        if (state_reg == CMD) begin
                            addr_reg       <= cmd_addr(rx_byte);
                            write_mode_reg <= rx_byte[W_BIT];
                            if (rx_byte[W_BIT]) shift_out_reg <= 8'h00;
                            else                pend1_reg     <= 1'b1;
                        end else if (write_mode_reg) begin
                            wr_strobe_reg <= 1'b1;
                            wr_addr_reg   <= addr_reg;
                            wr_data_reg   <= rx_byte;
                            addr_reg      <= addr_reg + 1'b1;
                            shift_out_reg <= 8'h00;
                        end else begin
                            addr_reg  <= addr_reg + 1'b1;
                            pend1_reg <= 1'b1;
                        end
                    end
                end else if (sclk_fall) begin
                    miso_bit_reg  <= shift_out_reg[7];
                    shift_out_reg <= {shift_out_reg[6:0], 1'b0};
                end
                if (pend2_reg) shift_out_reg <= spi_rd_reg;
            end
        end
    end

    // The write lands at the end of the strobe cycle, so a same-cycle fabric read sees the old byte.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else if (wr_strobe_reg) begin
            regs[wr_addr_reg] <= wr_data_reg;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) rd_data_reg <= 8'h00;
        else       rd_data_reg <= regs[RdAddr];
    end

    assign MISO     = miso_reg;
    assign Busy     = (state_reg != IDLE);
    assign MISO_OE  = Busy && !ss_level;
    assign RdData   = rd_data_reg;
    assign WrStrobe = wr_strobe_reg;
    assign WrAddr   = wr_addr_reg;
    assign WrData   = wr_data_reg;

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: a bit-banged SPI master plus a register-file model checked every cycle.
module tb_spi_responder;

    localparam int HALF = 8;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       SCLK = 1'b0;
    logic       SS_n = 1'b1;
    logic       MOSI = 1'b0;
    logic [7:0] Status = 8'hC3;
    logic [4:0] RdAddr = 5'd0;
    logic       MISO, MISO_OE, WrStrobe, Busy;
    logic [7:0] RdData, WrData;
    logic [4:0] WrAddr;

    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
    } wr_t;

    int         total = 0;
    int         bad = 0;
    int         strobes_seen = 0;
    wr_t        exp_q [$];
    logic [7:0] model_regs [32];
    logic [7:0] pend_rd = 8'h00;
    logic [4:0] last_wa = 5'd0;
    logic [7:0] last_wd = 8'h00;
    logic [7:0] tx_buf [4];
    logic [7:0] rx_buf [4];

    spi_responder #(.SYNC_STAGES(2)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .SCLK     (SCLK),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .MISO_OE  (MISO_OE),
        .Status   (Status),
        .RdAddr   (RdAddr),
        .RdData   (RdData),
        .WrStrobe (WrStrobe),
        .WrAddr   (WrAddr),
        .WrData   (WrData),
        .Busy     (Busy)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Model: register file, expected write strobes, registered fabric read with read-before-write.
    always @(negedge Clk) begin
        wr_t e;
        if (Reset) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 8'h00;
            exp_q.delete();
            pend_rd = 8'h00;
            last_wa = 5'd0;
            last_wd = 8'h00;
        end else begin
            total++;
            if (RdData !== pend_rd) begin
                bad++;
                $display("FAIL rd_data: got %02h want %02h", RdData, pend_rd);
            end
            pend_rd = model_regs[RdAddr];
            total++;
            if (WrStrobe === 1'b1) begin
                strobes_seen++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL wr_strobe_unexpected: got addr %0d data %02h want none", WrAddr, WrData);
                end else begin
                    e = exp_q.pop_front();
                    if (WrAddr !== e.a || WrData !== e.d) begin
                        bad++;
                        $display("FAIL wr_strobe: got addr %0d data %02h want addr %0d data %02h",
                                 WrAddr, WrData, e.a, e.d);
                    end
                    model_regs[e.a] = e.d;
                    last_wa = e.a;
                    last_wd = e.d;
                end
            end else if (WrStrobe !== 1'b0 || WrAddr !== last_wa || WrData !== last_wd) begin
                bad++;
                $display("FAIL wr_hold: got strobe %b addr %0d data %02h want strobe 0 addr %0d data %02h",
                         WrStrobe, WrAddr, WrData, last_wa, last_wd);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nb; i--) begin
            MOSI = tx[i];
            wait_clk(HALF);
            rx[i] = MISO;
            SCLK = 1'b1;
            wait_clk(HALF);
            SCLK = 1'b0;
        end
    endtask

    task automatic ss_low();
        wait_clk(2);
        SS_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic ss_high();
        wait_clk(HALF);
        SS_n = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic spi_write(input logic [4:0] a, input logic [2:0] low, input int n);
        logic [7:0] rx;
        logic [4:0] ad;
        wr_t        e;
        ss_low();
        spi_bits({a, low}, 8, rx);
        check8("wr_cmd_status", rx, Status);
        ad = a;
        for (int k = 0; k < n; k++) begin
            e.a = ad;
            e.d = tx_buf[k];
            exp_q.push_back(e);
            spi_bits(tx_buf[k], 8, rx);
            check8("wr_data_miso", rx, 8'h00);
            ad = ad + 5'd1;
        end
        ss_high();
    endtask

    task automatic spi_read(input logic [4:0] a, input logic [2:0] low, input int n);
        logic [7:0] rx;
        logic [4:0] ad;
        ss_low();
        spi_bits({a, low}, 8, rx);
        rx_buf[0] = rx;
        check8("rd_cmd_status", rx, Status);
        ad = a;
        for (int k = 1; k <= n; k++) begin
            spi_bits(8'h00, 8, rx);
            rx_buf[k] = rx;
            check8("rd_data_miso", rx, model_regs[ad]);
            ad = ad + 5'd1;
        end
        ss_high();
    endtask

    task automatic fab_read(input logic [4:0] a, output logic [7:0] d);
        RdAddr = a;
        wait_clk(1);
        d = RdData;
    endtask

    task automatic check_reset_outputs(input string tag);
        check8({tag, "_miso"}, {7'd0, MISO}, 8'h00);
        check8({tag, "_miso_oe"}, {7'd0, MISO_OE}, 8'h00);
        check8({tag, "_rd_data"}, RdData, 8'h00);
        check8({tag, "_wr_strobe"}, {7'd0, WrStrobe}, 8'h00);
        check8({tag, "_wr_addr"}, {3'd0, WrAddr}, 8'h00);
        check8({tag, "_wr_data"}, WrData, 8'h00);
        check8({tag, "_busy"}, {7'd0, Busy}, 8'h00);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] rx;
        int         n;
        int         seen_before;
        wr_t        e;

        wait_clk(5);
        Reset = 1'b0;
        wait_clk(1);
        check_reset_outputs("reset");

        // SCLK activity with the select high must be ignored.
        seen_before = strobes_seen;
        for (int i = 0; i < 4; i++) begin
            SCLK = 1'b1;
            wait_clk(HALF);
            SCLK = 1'b0;
            wait_clk(HALF);
        end
        check8("idle_sclk_busy", {7'd0, Busy}, 8'h00);
        check_int("idle_sclk_strobes", strobes_seen, seen_before);

        // Collision: fabric reads address 5 in the strobe cycle of an SPI write to 5.
        RdAddr = 5'd5;
        tx_buf[0] = 8'h77;
        fork
            spi_write(5'd5, 3'b010, 1);
            begin
                int wn;
                wn = 0;
                while (wn < 600 && WrStrobe !== 1'b1) begin
                    @(negedge Clk);
                    wn++;
                end
                if (wn >= 600) begin
                    check_int("coll_strobe_timeout", wn, 0);
                end else begin
                    @(negedge Clk);
                    check8("coll_old", RdData, 8'h00);
                    @(negedge Clk);
                    check8("coll_new", RdData, 8'h77);
                end
            end
        join

        // Write burst: 0x2A, 0x11, 0x22.
        tx_buf[0] = 8'h11;
        tx_buf[1] = 8'h22;
        spi_write(5'd5, 3'b010, 2);
        fab_read(5'd6, d);
        check8("burst_rd6", d, 8'h22);
        fab_read(5'd5, d);
        check8("burst_rd5", d, 8'h11);

        // Read with status.
        Status = 8'hA5;
        tx_buf[0] = 8'h3C;
        spi_write(5'd9, 3'b010, 1);
        spi_read(5'd9, 3'b000, 2);
        check8("rdst_cmd", rx_buf[0], 8'hA5);
        check8("rdst_data", rx_buf[1], 8'h3C);
        check8("rdst_next", rx_buf[2], 8'h00);

        // Address wrap in both directions; ignored command bits set.
        tx_buf[0] = 8'h01;
        tx_buf[1] = 8'h02;
        tx_buf[2] = 8'h03;
        spi_write(5'd31, 3'b111, 3);
        fab_read(5'd31, d);
        check8("wrap_rd31", d, 8'h01);
        fab_read(5'd0, d);
        check8("wrap_rd0", d, 8'h02);
        fab_read(5'd1, d);
        check8("wrap_rd1", d, 8'h03);
        Status = 8'h5E;
        spi_read(5'd31, 3'b101, 2);
        check8("wrap_spi_rd31", rx_buf[1], 8'h01);
        check8("wrap_spi_rd0", rx_buf[2], 8'h02);

        // Abort after 5 data bits.
        seen_before = strobes_seen;
        ss_low();
        spi_bits({5'd12, 3'b010}, 8, rx);
        spi_bits(8'hFF, 5, rx);
        check8("abort_busy_mid", {7'd0, Busy}, 8'h01);
        check8("abort_oe_mid", {7'd0, MISO_OE}, 8'h01);
        wait_clk(2);
        SS_n = 1'b1;
        n = 0;
        while (n < 8) begin
            wait_clk(1);
            n++;
            if (Busy == 1'b0) break;
        end
        total++;
        if (n > 4 || Busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_busy_drop: got %0d clk busy %b want <=4 clk busy 0", n, Busy);
        end
        wait_clk(HALF);
        check_int("abort_strobes", strobes_seen, seen_before);
        fab_read(5'd12, d);
        check8("abort_reg12", d, 8'h00);

        // Reset in the middle of the second data byte.
        ss_low();
        spi_bits({5'd20, 3'b010}, 8, rx);
        e.a = 5'd20;
        e.d = 8'h55;
        exp_q.push_back(e);
        spi_bits(8'h55, 8, rx);
        spi_bits(8'h66, 4, rx);
        Reset = 1'b1;
        wait_clk(3);
        Reset = 1'b0;
        wait_clk(1);
        check_reset_outputs("midrst");
        for (int i = 0; i < 32; i++) begin
            RdAddr = 5'(i);
            wait_clk(1);
        end
        fab_read(5'd20, d);
        check8("midrst_reg20", d, 8'h00);
        fab_read(5'd9, d);
        check8("midrst_reg9", d, 8'h00);
        wait_clk(HALF);
        check8("midrst_held_ss_busy", {7'd0, Busy}, 8'h00);
        SS_n = 1'b1;
        wait_clk(HALF);
        tx_buf[0] = 8'h99;
        spi_write(5'd3, 3'b010, 1);
        fab_read(5'd3, d);
        check8("post_rst_write", d, 8'h99);

        wait_clk(4);
        check_int("pending_strobes", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
